mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multi-cycle main control unit for the MIPS-style core; the successor to the single-cycle combinational opcode decoder. It sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK per instruction and drives all datapath enables from the current state. It waits on a memory ready handshake and flags a memory timeout. It sits between the instruction register opcode field and the multi-cycle datapath (PC, IR, register file, ALU, memory port).

Parameters:
MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in any memory state before error (1..255)
TMR_W, $clog2(MEM_TIMEOUT+1), wait-counter width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], sampled in DECODE
mem_ready  in  1  memory transfer complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs register
ir_write  out  1  IR load
iord  out  1  0 address from PC, 1 address from ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  1 writeback from MDR, 0 from ALUOut/PC
reg_dst  out  2  00 rt, 01 rd, 10 $31
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 logic-imm (decoded from opcode)
mem_err  out  1  sticky memory timeout flag
trap  out  1  illegal-opcode pulse (see Optional Feature)

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, addi 001000, andi 001100, ori 001101, beq 000100, jr 100000, j 110000, jal 111000.
- Reset (async, rst_n=0): state FETCH, wait counter 0, mem_err 0. All outputs 0 except FETCH-state Moore values once released. No pc_write or ir_write is asserted while rst_n=0.
- Outputs are Moore-decoded from state. Exception: in FETCH, ir_write and pc_write equal mem_ready.
- Unlisted outputs are 0 in every state.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. Holds until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - lw/sw go to MEM_ADDR; R goes to R_EXEC; addi/andi/ori go to I_EXEC; beq goes to BRANCH; j goes to JUMP; jal goes to JAL; jr goes to JUMP_REG.
  - Any other opcode goes to FETCH (NOP).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_RD: mem_read=1, iord=1; holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=00, then FETCH.
- MEM_WR: mem_write=1, iord=1; holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then ALU_WB with reg_dst=01.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for addi or 11 for andi/ori, then ALU_WB with reg_dst=00.
- ALU_WB: reg_write=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then FETCH.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- JUMP_REG: pc_write=1, pc_source=11, then FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=0 (writeback selects PC+4 via the datapath link path), then FETCH.
- Latency with mem_ready tied 1:
  - R/addi/andi/ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/j/jr/jal: 3 cycles.
  - Unknown opcode: 2 cycles.
- Wait counter:
  - Clears on entry to any memory state (FETCH, MEM_RD, MEM_WR).
  - Increments each cycle mem_ready=0 in those states.
  - When it reaches MEM_TIMEOUT, the next state is HALT and mem_err is set.
  - mem_ready in the same cycle the counter reaches MEM_TIMEOUT wins: the transfer completes and there is no error.
- HALT: all outputs 0, mem_err=1; exits only via reset.
- Reset asserted mid-instruction: immediate return to FETCH; the partial instruction is abandoned and no write completes.

Optional Feature:
MC_CTRL_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP asserts trap=1 for exactly one cycle with pc_write=1 and pc_source=10 (the datapath supplies the exception vector), then goes to FETCH.
- Undefined: the TRAP state does not exist, trap is tied 0, and unknown opcodes are NOPs.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - Opcode localparams.
  - State enum (4-bit: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, I_EXEC, ALU_WB, BRANCH, JUMP, JUMP_REG, JAL, TRAP, HALT).
  - alu_op, pc_source, reg_dst and alu_src_b encodings.
- One sub-module, mc_mem_wait_timer: a clear/increment/terminal-count counter parametrised by MEM_TIMEOUT.

Test Plan:
- Reset release, mem_ready=1, opcode=000000: states FETCH, DECODE, R_EXEC, ALU_WB in 4 cycles; reg_write=1 with reg_dst=01 in cycle 4; ir_write=1 in cycle 1.
- opcode=100011, mem_ready low 3 cycles in MEM_RD: MEM_RD is held 4 cycles with iord=1, then MEM_WB asserts reg_write=1 and mem_to_reg=1.
- opcode=111000: JAL cycle asserts pc_write=1, pc_source=10, reg_write=1, reg_dst=10; next state FETCH.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: HALT after 4 wait cycles, mem_err=1 held, no pc_write; rst_n pulse clears mem_err.
- mem_ready=1 exactly on the terminal-count cycle: mem_err stays 0 and DECODE follows.
- opcode=111111: without the macro, FETCH follows DECODE and trap=0; with MC_CTRL_ILLEGAL_TRAP_EN, a one-cycle trap=1 and pc_write=1, then FETCH.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, state codes,
// datapath mux encodings and the memory-state classifier.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JR   = 6'b100000;
    localparam logic [5:0] OP_J    = 6'b110000;
    localparam logic [5:0] OP_JAL  = 6'b111000;

    typedef logic [3:0] state_t;

    localparam state_t ST_FETCH    = 4'd0;
    localparam state_t ST_DECODE   = 4'd1;
    localparam state_t ST_MEM_ADDR = 4'd2;
    localparam state_t ST_MEM_RD   = 4'd3;
    localparam state_t ST_MEM_WB   = 4'd4;
    localparam state_t ST_MEM_WR   = 4'd5;
    localparam state_t ST_R_EXEC   = 4'd6;
    localparam state_t ST_I_EXEC   = 4'd7;
    localparam state_t ST_ALU_WB   = 4'd8;
    localparam state_t ST_BRANCH   = 4'd9;
    localparam state_t ST_JUMP     = 4'd10;
    localparam state_t ST_JUMP_REG = 4'd11;
    localparam state_t ST_JAL      = 4'd12;
    localparam state_t ST_TRAP     = 4'd13;
    localparam state_t ST_HALT     = 4'd14;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // States that wait on the memory handshake and are guarded by the timer.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the instruction register / memory port and the
// multi-cycle datapath; master is the control unit, slave the datapath side.
interface mc_ctrl_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_err;
    logic       trap;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
               mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, mem_err, trap
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
               mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, mem_err, trap
    );

endinterface

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// Memory wait counter: counts consecutive stalled cycles and flags the cycle
// on which the count would reach MEM_TIMEOUT.
module mc_mem_wait_timer #(
    parameter int  MEM_TIMEOUT = 16,
    localparam int TMR_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output logic expire
);

    logic [TMR_W-1:0] cnt;

    // Any cycle without a stall clears the count, so every memory state is entered at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + TMR_W'(1);
        else
            cnt <= '0;
    end

    assign expire = inc && (cnt == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM with memory timeout detection.
// Optional illegal-opcode trap state enabled by MC_CTRL_ILLEGAL_TRAP_EN.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mc_ctrl_if.master  ctrl
);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] op_q;
    logic       mem_err_q;
    logic       stall;
    logic       expire;

    assign stall = is_mem_state(state) && !ctrl.mem_ready;

    mc_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (stall),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (ctrl.mem_ready)
                    state_nxt = ST_DECODE;
                else if (expire)
                    state_nxt = ST_HALT;
            end
            ST_DECODE: begin
                case (ctrl.opcode)
                    OP_LW, OP_SW:              state_nxt = ST_MEM_ADDR;
                    OP_R:                      state_nxt = ST_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_nxt = ST_I_EXEC;
                    OP_BEQ:                    state_nxt = ST_BRANCH;
                    OP_J:                      state_nxt = ST_JUMP;
                    OP_JAL:                    state_nxt = ST_JAL;
                    OP_JR:                     state_nxt = ST_JUMP_REG;
                    default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state_nxt = ST_TRAP;
`else
                        state_nxt = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM_ADDR: state_nxt = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (ctrl.mem_ready)
                    state_nxt = ST_MEM_WB;
                else if (expire)
                    state_nxt = ST_HALT;
            end
            ST_MEM_WR: begin
                if (ctrl.mem_ready)
                    state_nxt = ST_FETCH;
                else if (expire)
                    state_nxt = ST_HALT;
            end
            ST_R_EXEC, ST_I_EXEC: state_nxt = ST_ALU_WB;
            ST_HALT:              state_nxt = ST_HALT;
            default:              state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (expire)
                mem_err_q <= 1'b1;
        end
    end

    // Opcode is only consumed after DECODE, so the latch carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_DECODE)
            op_q <= ctrl.opcode;
    end

    always_comb begin
        ctrl.pc_write      = 1'b0;
        ctrl.pc_write_cond = 1'b0;
        ctrl.pc_source     = PC_ALU;
        ctrl.ir_write      = 1'b0;
        ctrl.iord          = 1'b0;
        ctrl.mem_read      = 1'b0;
        ctrl.mem_write     = 1'b0;
        ctrl.mem_to_reg    = 1'b0;
        ctrl.reg_dst       = RD_RT;
        ctrl.reg_write     = 1'b0;
        ctrl.alu_src_a     = 1'b0;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_ADD;
        ctrl.mem_err       = mem_err_q;
        ctrl.trap          = 1'b0;
        // Everything is held low while reset is asserted, including the FETCH strobes.
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.ir_write  = ctrl.mem_ready;
                    ctrl.pc_write  = ctrl.mem_ready;
                end
                ST_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
                ST_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                ST_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                ST_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                ST_I_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = (op_q == OP_ADDI) ? ALU_ADD : ALU_LOGIC;
                end
                ST_ALU_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = (op_q == OP_R) ? RD_RD : RD_RT;
                end
                ST_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PC_ALUOUT;
                end
                ST_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_JUMP;
                end
                ST_JUMP_REG: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_RS;
                end
                ST_JAL: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_JUMP;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RA;
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    ctrl.trap      = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_JUMP;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected control sequences built
// from the instruction semantics, driven with directed and random handshakes.
module tb_mc_control_fsm;

    localparam int TO = 4;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_ANDI = 6'b001100;
    localparam logic [5:0] O_ORI  = 6'b001101;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [5:0] O_JR   = 6'b100000;
    localparam logic [5:0] O_J    = 6'b110000;
    localparam logic [5:0] O_JAL  = 6'b111000;

    // Observed/expected word: pw pwc ps[2] irw iord mr mw m2r rd[2] rw asa asb[2] aop[2] err trap
    localparam logic [18:0] PW   = 19'h40000;
    localparam logic [18:0] PWC  = 19'h20000;
    localparam logic [18:0] IRW  = 19'h04000;
    localparam logic [18:0] IORD = 19'h02000;
    localparam logic [18:0] MR   = 19'h01000;
    localparam logic [18:0] MW   = 19'h00800;
    localparam logic [18:0] M2R  = 19'h00400;
    localparam logic [18:0] RW   = 19'h00080;
    localparam logic [18:0] ASA  = 19'h00040;
    localparam logic [18:0] ERR  = 19'h00002;
    localparam logic [18:0] TRP  = 19'h00001;

    function automatic logic [18:0] f_ps(input logic [1:0] v);
        return {2'b00, v, 15'b0};
    endfunction
    function automatic logic [18:0] f_rd(input logic [1:0] v);
        return {9'b0, v, 8'b0};
    endfunction
    function automatic logic [18:0] f_asb(input logic [1:0] v);
        return {13'b0, v, 4'b0};
    endfunction
    function automatic logic [18:0] f_aop(input logic [1:0] v);
        return {15'b0, v, 2'b0};
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_if ctrl();

    mc_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ctrl)
    );

    typedef struct {
        string       name;
        logic [18:0] cw;
        bit          mem;
        bit          fetch;
    } step_t;

    step_t steps[$];

    function automatic void add(input string n, input logic [18:0] cw, input bit mem, input bit fetch);
        step_t s;
        s.name  = n;
        s.cw    = cw;
        s.mem   = mem;
        s.fetch = fetch;
        steps.push_back(s);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction
    function automatic void build(input logic [5:0] op);
        steps.delete();
        add("fetch", MR | f_asb(2'b01), 1'b1, 1'b1);
        add("decode", f_asb(2'b11), 1'b0, 1'b0);
        case (op)
            O_LW: begin
                add("mem_addr", ASA | f_asb(2'b10), 1'b0, 1'b0);
                add("mem_rd", MR | IORD, 1'b1, 1'b0);
                add("mem_wb", RW | M2R, 1'b0, 1'b0);
            end
            O_SW: begin
                add("mem_addr", ASA | f_asb(2'b10), 1'b0, 1'b0);
                add("mem_wr", MW | IORD, 1'b1, 1'b0);
            end
            O_R: begin
                add("r_exec", ASA | f_asb(2'b00) | f_aop(2'b10), 1'b0, 1'b0);
                add("r_wb", RW | f_rd(2'b01), 1'b0, 1'b0);
            end
            O_ADDI: begin
                add("addi_exec", ASA | f_asb(2'b10), 1'b0, 1'b0);
                add("i_wb", RW, 1'b0, 1'b0);
            end
            O_ANDI, O_ORI: begin
                add("logic_exec", ASA | f_asb(2'b10) | f_aop(2'b11), 1'b0, 1'b0);
                add("i_wb", RW, 1'b0, 1'b0);
            end
            O_BEQ: add("branch", ASA | f_aop(2'b01) | PWC | f_ps(2'b01), 1'b0, 1'b0);
            O_J:   add("jump", PW | f_ps(2'b10), 1'b0, 1'b0);
            O_JR:  add("jump_reg", PW | f_ps(2'b11), 1'b0, 1'b0);
            O_JAL: add("jal", PW | f_ps(2'b10) | RW | f_rd(2'b10), 1'b0, 1'b0);
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                add("trap", PW | f_ps(2'b10) | TRP, 1'b0, 1'b0);
`endif
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [18:0] exp);
        logic [18:0] got;
        got = {ctrl.pc_write, ctrl.pc_write_cond, ctrl.pc_source, ctrl.ir_write,
               ctrl.iord, ctrl.mem_read, ctrl.mem_write, ctrl.mem_to_reg,
               ctrl.reg_dst, ctrl.reg_write, ctrl.alu_src_a, ctrl.alu_src_b,
               ctrl.alu_op, ctrl.mem_err, ctrl.trap};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns shortly after a rising edge with reset released.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        ctrl.mem_ready = 1'b1;
        ctrl.opcode = 6'($urandom);
        #1;
        check(tag, '0);
        @(posedge clk);
        #2;
        check(tag, '0);
        rst_n = 1'b1;
    endtask

    task automatic halt_check();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ctrl.mem_ready = 1'($urandom_range(0, 1));
            ctrl.opcode = 6'($urandom);
            #1;
            check("halt", ERR);
        end
    endtask

    // stall < 0 means random handshake; abort_at is the step index at which reset hits.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int dstall,
                             input int abort_at, output bit halted);
        int idx;
        int waits;
        int stall;
        logic mr;
        logic [18:0] exp;
        build(op);
        halted = 1'b0;
        idx = 0;
        waits = 0;
        while (idx < steps.size()) begin
            @(negedge clk);
            if (idx == abort_at) begin
                do_reset("abort_reset");
                return;
            end
            stall = (idx == 0) ? fstall : dstall;
            if (steps[idx].mem)
                mr = (stall >= 0) ? (waits >= stall) : ($urandom_range(0, 99) < 65);
            else
                mr = 1'($urandom_range(0, 1));
            ctrl.mem_ready = mr;
            ctrl.opcode = (idx == 1) ? op : 6'($urandom);
            #1;
            exp = steps[idx].cw;
            if (steps[idx].fetch && mr)
                exp = exp | PW | IRW;
            check(steps[idx].name, exp);
            if (steps[idx].mem) begin
                if (mr) begin
                    idx++;
                    waits = 0;
                end else begin
                    waits++;
                    if (waits == TO) begin
                        halted = 1'b1;
                        break;
                    end
                end
            end else begin
                idx++;
            end
        end
    endtask

    initial begin
        bit h;
        logic [5:0] ops[10];
        logic [5:0] op;
        int abort_at;
        ops = '{O_R, O_LW, O_SW, O_ADDI, O_ANDI, O_ORI, O_BEQ, O_JR, O_J, O_JAL};
        ctrl.mem_ready = 1'b1;
        ctrl.opcode = 6'b0;

        @(negedge clk);
        do_reset("reset");

        run_instr(O_R, 0, 0, -1, h);
        run_instr(O_LW, 0, 3, -1, h);
        run_instr(O_JAL, 0, 0, -1, h);
        run_instr(O_SW, 1, 2, -1, h);

        // Fetch never answers: timeout into HALT, then reset recovers
        run_instr(O_R, TO, 0, -1, h);
        if (h) halt_check();
        @(negedge clk);
        do_reset("halt_reset");

        // Ready on the terminal-count cycle completes the fetch
        run_instr(O_ADDI, TO - 1, 0, -1, h);
        run_instr(O_LW, 0, TO, -1, h);
        if (h) halt_check();
        @(negedge clk);
        do_reset("halt_reset");

        run_instr(6'b111111, 0, 0, -1, h);
        run_instr(O_BEQ, 0, 0, -1, h);

        // Reset while the load is waiting on memory abandons it
        run_instr(O_LW, 0, 2, 3, h);
        run_instr(O_ORI, 0, 0, -1, h);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                for (int k = 0; k < 10; k++)
                    if (op == ops[k]) op = 6'b111111;
            end else begin
                op = ops[$urandom_range(0, 9)];
            end
            abort_at = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : -1;
            run_instr(op, -1, -1, abort_at, h);
            if (h) begin
                halt_check();
                @(negedge clk);
                do_reset("halt_reset");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
